// File: rtl/id_pkg.sv
// Shared decode definitions for the ID/issue stage.
// This package holds the RV32I opcode constants, the ALU and operand-select
// encodings, the registered ID/EX bundle type, the instruction decoder, and
// the source-use and writer predicates that drive the scoreboard.
package id_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_func_e;

  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;
  typedef enum logic [1:0] {OPB_RS2, OPB_IMM, OPB_FOUR} opb_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] ra_value;
    logic [DATA_W-1:0] rb_value;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              pc_add_opa;    // branch/jump target base is ra, not PC
    opa_sel_e          opa_select;
    opb_sel_e          opb_select;
    alu_func_e         alu_func;
    logic [2:0]        funct3;
    logic [4:0]        dest_reg_idx;
    logic              reg_wr;
    logic              rd_mem;
    logic              wr_mem;
    logic              cond_branch;
    logic              uncond_branch;
    logic              illegal;
  } dec_bundle_t;

  function automatic alu_func_e alu_of(input logic [2:0] f3, input logic alt);
    alu_func_e a;
    case (f3)
      3'd0:    a = alt ? ALU_SUB : ALU_ADD;
      3'd1:    a = ALU_SLL;
      3'd2:    a = ALU_SLT;
      3'd3:    a = ALU_SLTU;
      3'd4:    a = ALU_XOR;
      3'd5:    a = alt ? ALU_SRA : ALU_SRL;
      3'd6:    a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  // Operand values are left zero; the stage fills them after the register read.
  function automatic dec_bundle_t decode(input logic [31:0] ir, input logic [DATA_W-1:0] pc);
    dec_bundle_t b;
    logic        wr;
    logic        bad;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3           = ir[14:12];
    f7           = ir[31:25];
    b            = '0;
    b.pc         = pc;
    b.funct3     = f3;
    b.opa_select = OPA_RS1;
    b.opb_select = OPB_IMM;
    b.alu_func   = ALU_ADD;
    wr           = 1'b0;
    bad          = 1'b0;
    case (ir[6:0])
      OP_LUI: begin
        b.imm = {ir[31:12], 12'b0}; b.opa_select = OPA_ZERO; wr = 1'b1;
      end
      OP_AUIPC: begin
        b.imm = {ir[31:12], 12'b0}; b.opa_select = OPA_PC; wr = 1'b1;
      end
      OP_JAL: begin
        b.imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
        b.opa_select = OPA_PC; b.opb_select = OPB_FOUR; b.uncond_branch = 1'b1; wr = 1'b1;
      end
      OP_JALR: begin
        b.imm = {{20{ir[31]}}, ir[31:20]};
        b.opa_select = OPA_PC; b.opb_select = OPB_FOUR; b.pc_add_opa = 1'b1;
        b.uncond_branch = 1'b1; wr = 1'b1; bad = (f3 != 3'd0);
      end
      OP_BRANCH: begin
        b.imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
        b.opb_select = OPB_RS2; b.alu_func = ALU_SUB; b.cond_branch = 1'b1;
        bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_LOAD: begin
        b.imm = {{20{ir[31]}}, ir[31:20]}; b.rd_mem = 1'b1; wr = 1'b1;
        bad = (f3[1:0] == 2'd3) || (f3 == 3'd6);
      end
      OP_STORE: begin
        b.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]}; b.wr_mem = 1'b1;
        bad = (f3 > 3'd2);
      end
      OP_IMM: begin
        b.imm = {{20{ir[31]}}, ir[31:20]}; wr = 1'b1;
        b.alu_func = alu_of(f3, (f3 == 3'd5) && ir[30]);
        bad = ((f3 == 3'd1) && (f7 != 7'h00)) ||
              ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OP_OP: begin
        b.opb_select = OPB_RS2; wr = 1'b1;
        b.alu_func = alu_of(f3, ir[30]);
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      wr = 1'b0; b.rd_mem = 1'b0; b.wr_mem = 1'b0;
      b.cond_branch = 1'b0; b.uncond_branch = 1'b0;
    end
    b.illegal      = bad;
    b.reg_wr       = wr && (ir[11:7] != 5'd0);
    b.dest_reg_idx = b.reg_wr ? ir[11:7] : 5'd0;
    return b;
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ir);
    return (ir[6:0] == OP_OP) || (ir[6:0] == OP_IMM) || (ir[6:0] == OP_LOAD) ||
           (ir[6:0] == OP_STORE) || (ir[6:0] == OP_BRANCH) || (ir[6:0] == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    return (ir[6:0] == OP_OP) || (ir[6:0] == OP_STORE) || (ir[6:0] == OP_BRANCH);
  endfunction

  function automatic logic is_writer(input dec_bundle_t b);
    return b.reg_wr && (b.dest_reg_idx != 5'd0) && !b.illegal;
  endfunction

endpackage

// File: rtl/id_issue_stage_if.sv
// Bus between IF/ID, the issue stage, writeback and EX.
// Ports: IF/ID instruction + valid, id_ready_out back-pressure, flush,
// writeback qualifiers/index/data, and the registered ID/EX valid + bundle.
// slave = the issue stage, master = its environment.
interface id_issue_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
);
  import id_pkg::*;

  logic              if_id_valid_inst;
  logic [31:0]       if_id_IR;
  logic [XLEN-1:0]   if_id_PC;
  logic              id_ready_out;
  logic              ex_ready_in;
  logic              flush;
  logic              wb_valid_inst;
  logic              wb_reg_wr;
  logic [RW-1:0]     wb_dest_reg_idx;
  logic [XLEN-1:0]   wb_data;
  logic              id_ex_valid;
  dec_bundle_t       id_ex_bundle;

  modport master (
    output if_id_valid_inst, if_id_IR, if_id_PC, ex_ready_in, flush,
           wb_valid_inst, wb_reg_wr, wb_dest_reg_idx, wb_data,
    input  id_ready_out, id_ex_valid, id_ex_bundle
  );

  modport slave (
    input  if_id_valid_inst, if_id_IR, if_id_PC, ex_ready_in, flush,
           wb_valid_inst, wb_reg_wr, wb_dest_reg_idx, wb_data,
    output id_ready_out, id_ex_valid, id_ex_bundle
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters.
// Ports: clk, rst (sync, active-high); i_inc/i_inc_idx (writer issued),
// i_dec/i_dec_idx (writeback), i_squash/i_squash_idx (flushed writer);
// i_q_rs1/i_q_rs2/i_q_rd with combinational counts o_cnt_rs1/o_cnt_rs2/o_cnt_rd.
module reg_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_inc,
  input  logic [$clog2(NREGS)-1:0] i_inc_idx,
  input  logic                     i_dec,
  input  logic [$clog2(NREGS)-1:0] i_dec_idx,
  input  logic                     i_squash,
  input  logic [$clog2(NREGS)-1:0] i_squash_idx,
  input  logic [$clog2(NREGS)-1:0] i_q_rs1,
  input  logic [$clog2(NREGS)-1:0] i_q_rs2,
  input  logic [$clog2(NREGS)-1:0] i_q_rd,
  output logic [CNT_W-1:0]         o_cnt_rs1,
  output logic [CNT_W-1:0]         o_cnt_rs2,
  output logic [CNT_W-1:0]         o_cnt_rd
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned SW = CNT_W + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt [NREGS];
  logic [SW-1:0]    w_up  [NREGS];
  logic [SW-1:0]    w_dn  [NREGS];
  logic [CNT_W-1:0] w_nxt [NREGS];

  // Events on one register sum; an over-decrement clamps at zero.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      w_up[i]  = SW'(r_cnt[i]) + SW'(i_inc && (i_inc_idx == RW'(i)));
      w_dn[i]  = SW'(i_dec && (i_dec_idx == RW'(i))) +
                 SW'(i_squash && (i_squash_idx == RW'(i)));
      w_nxt[i] = '0;
      if (w_dn[i] <= w_up[i]) begin
        w_nxt[i] = ((w_up[i] - w_dn[i]) > CNT_MAX) ? '1 : CNT_W'(w_up[i] - w_dn[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      r_cnt[i] <= rst ? '0 : w_nxt[i];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        assert (w_dn[i] <= w_up[i])
          else $error("scoreboard decrement below zero on register %0d", i);
      end
    end
  end
`endif

  assign o_cnt_rs1 = r_cnt[i_q_rs1];
  assign o_cnt_rs2 = r_cnt[i_q_rs2];
  assign o_cnt_rd  = r_cnt[i_q_rd];
endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes IF/ID, reads the register file, blocks RAW and
// writer-overflow hazards through reg_scoreboard, and issues into a registered
// ID/EX slot under a valid/ready handshake with flush recovery.
// Ports: clk, rst (sync, active-high); bus (id_issue_stage_if.slave) carrying
// IF/ID, id_ready_out, ex_ready_in, flush, writeback and ID/EX outputs.
// Build option: define WB_BYPASS_EN to let a source with a single pending
// writer issue in that writer's writeback cycle, taking wb_data directly.
module id_issue_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 2
) (
  input logic              clk,
  input logic              rst,
  id_issue_stage_if.slave  bus
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  r_rf [NREGS];
  logic             r_id_ex_valid;
  dec_bundle_t      r_id_ex_bundle;

  dec_bundle_t      w_dec, w_bundle;
  logic [RW-1:0]    w_rs1, w_rs2, w_rd, w_wb_idx, w_sq_idx;
  logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2, w_cnt_rd;
  logic             w_wb_fire, w_byp1, w_byp2;
  logic             w_haz1, w_haz2, w_haz_rd, w_stall, w_ready, w_issue, w_writer, w_squash;
  logic [XLEN-1:0]  w_ra, w_rb;

  assign w_dec     = decode(bus.if_id_IR, bus.if_id_PC);
  assign w_rs1     = bus.if_id_IR[15 +: RW];
  assign w_rs2     = bus.if_id_IR[20 +: RW];
  assign w_rd      = w_dec.dest_reg_idx[RW-1:0];
  assign w_wb_idx  = bus.wb_dest_reg_idx;
  assign w_wb_fire = bus.wb_valid_inst && bus.wb_reg_wr && (w_wb_idx != '0);

`ifdef WB_BYPASS_EN
  assign w_byp1 = w_wb_fire && (w_wb_idx == w_rs1);
  assign w_byp2 = w_wb_fire && (w_wb_idx == w_rs2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // The bypass only clears the hazard when this writeback is the last pending writer.
  assign w_haz1   = uses_rs1(bus.if_id_IR) && (w_rs1 != '0) && (w_cnt_rs1 != '0) &&
                    !(w_byp1 && (w_cnt_rs1 == CNT_ONE));
  assign w_haz2   = uses_rs2(bus.if_id_IR) && (w_rs2 != '0) && (w_cnt_rs2 != '0) &&
                    !(w_byp2 && (w_cnt_rs2 == CNT_ONE));
  assign w_writer = is_writer(w_dec);
  assign w_haz_rd = w_writer && (w_cnt_rd == CNT_MAX);
  assign w_stall  = w_haz1 || w_haz2 || w_haz_rd;
  assign w_ready  = !w_stall && (!r_id_ex_valid || bus.ex_ready_in);
  assign w_issue  = bus.if_id_valid_inst && w_ready && !bus.flush;

  assign w_squash = bus.flush && r_id_ex_valid && is_writer(r_id_ex_bundle);
  assign w_sq_idx = r_id_ex_bundle.dest_reg_idx[RW-1:0];

  assign w_ra = (w_rs1 == '0) ? '0 : (w_byp1 ? bus.wb_data : r_rf[w_rs1]);
  assign w_rb = (w_rs2 == '0) ? '0 : (w_byp2 ? bus.wb_data : r_rf[w_rs2]);

  always_comb begin
    w_bundle          = w_dec;
    w_bundle.ra_value = w_ra;
    w_bundle.rb_value = w_rb;
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_issue && w_writer),
    .i_inc_idx    (w_rd),
    .i_dec        (w_wb_fire),
    .i_dec_idx    (w_wb_idx),
    .i_squash     (w_squash),
    .i_squash_idx (w_sq_idx),
    .i_q_rs1      (w_rs1),
    .i_q_rs2      (w_rs2),
    .i_q_rd       (w_rd),
    .o_cnt_rs1    (w_cnt_rs1),
    .o_cnt_rs2    (w_cnt_rs2),
    .o_cnt_rd     (w_cnt_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_fire) begin
      r_rf[w_wb_idx] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_ex_valid  <= 1'b0;
      r_id_ex_bundle <= '0;
    end else if (bus.flush) begin
      r_id_ex_valid  <= 1'b0;
    end else if (w_issue) begin
      r_id_ex_valid  <= 1'b1;
      r_id_ex_bundle <= w_bundle;
    end else if (bus.ex_ready_in) begin
      r_id_ex_valid  <= 1'b0;
    end
  end

  assign bus.id_ready_out = w_ready;
  assign bus.id_ex_valid  = r_id_ex_valid;
  assign bus.id_ex_bundle = r_id_ex_bundle;
endmodule

// File: tb/tb_id_issue_stage.sv
// Directed testbench for id_issue_stage (NREGS=32, CNT_W=2).
module tb_id_issue_stage;
  import id_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_issue_stage_if #(.XLEN(32), .RW(5)) bus ();

  id_issue_stage #(.XLEN(32), .NREGS(32), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_id_valid_inst = 1'b0;
    bus.if_id_IR         = '0;
    bus.if_id_PC         = '0;
    bus.ex_ready_in      = 1'b1;
    bus.flush            = 1'b0;
    bus.wb_valid_inst    = 1'b0;
    bus.wb_reg_wr        = 1'b0;
    bus.wb_dest_reg_idx  = '0;
    bus.wb_data          = '0;
  endtask

  task automatic present(input logic [31:0] ir, input logic [31:0] pc);
    bus.if_id_valid_inst = 1'b1;
    bus.if_id_IR         = ir;
    bus.if_id_PC         = pc;
  endtask

  task automatic wb(input logic [4:0] idx, input logic [31:0] d);
    bus.wb_valid_inst   = 1'b1;
    bus.wb_reg_wr       = 1'b1;
    bus.wb_dest_reg_idx = idx;
    bus.wb_data         = d;
  endtask

  task automatic wb_clear();
    bus.wb_valid_inst = 1'b0;
    bus.wb_reg_wr     = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.id_ex_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", bus.id_ex_valid);
    end
    checks++;
    if (bus.id_ex_bundle !== '0) begin
      errors++; $display("FAIL reset_bundle got %h exp 0", bus.id_ex_bundle);
    end
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b exp 1", bus.id_ready_out);
    end
    checks++;
    if (dut.u_sb.r_cnt[1] !== 2'd0) begin
      errors++; $display("FAIL reset_cnt1 got %0d exp 0", dut.u_sb.r_cnt[1]);
    end
  endtask

  task automatic test_raw();
    present(enc_addi(5'd1, 5'd0, 12'd5), 32'h100); #1;
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL raw_prod_ready got %0b exp 1", bus.id_ready_out);
    end
    tick();
    checks++;
    if (bus.id_ex_valid !== 1'b1 || bus.id_ex_bundle.dest_reg_idx !== 5'd1 ||
        bus.id_ex_bundle.imm !== 32'd5 || bus.id_ex_bundle.alu_func !== ALU_ADD) begin
      errors++; $display("FAIL raw_prod_issue got v=%0b rd=%0d imm=%0d exp v=1 rd=1 imm=5",
                         bus.id_ex_valid, bus.id_ex_bundle.dest_reg_idx, bus.id_ex_bundle.imm);
    end
    checks++;
    if (dut.u_sb.r_cnt[1] !== 2'd1) begin
      errors++; $display("FAIL raw_cnt_inc got %0d exp 1", dut.u_sb.r_cnt[1]);
    end
    present(enc_add(5'd2, 5'd1, 5'd1), 32'h104); #1;
    checks++;
    if (bus.id_ready_out !== 1'b0) begin
      errors++; $display("FAIL raw_stall got %0b exp 0", bus.id_ready_out);
    end
    tick();
    checks++;
    if (bus.id_ex_valid !== 1'b0) begin
      errors++; $display("FAIL raw_drain got %0b exp 0", bus.id_ex_valid);
    end
    tick();
    wb(5'd1, 32'd5); #1;
`ifdef WB_BYPASS_EN
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL raw_bypass_ready got %0b exp 1", bus.id_ready_out);
    end
    tick();
    wb_clear();
    bus.if_id_valid_inst = 1'b0;
`else
    checks++;
    if (bus.id_ready_out !== 1'b0) begin
      errors++; $display("FAIL raw_wb_cycle_ready got %0b exp 0", bus.id_ready_out);
    end
    tick();
    wb_clear(); #1;
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL raw_after_wb_ready got %0b exp 1", bus.id_ready_out);
    end
    tick();
    bus.if_id_valid_inst = 1'b0;
`endif
    checks++;
    if (bus.id_ex_valid !== 1'b1 || bus.id_ex_bundle.ra_value !== 32'd5 ||
        bus.id_ex_bundle.rb_value !== 32'd5 || bus.id_ex_bundle.dest_reg_idx !== 5'd2) begin
      errors++; $display("FAIL raw_dep_issue got v=%0b ra=%0d rb=%0d rd=%0d exp v=1 ra=5 rb=5 rd=2",
                         bus.id_ex_valid, bus.id_ex_bundle.ra_value,
                         bus.id_ex_bundle.rb_value, bus.id_ex_bundle.dest_reg_idx);
    end
    checks++;
    if (dut.u_sb.r_cnt[1] !== 2'd0 || dut.u_sb.r_cnt[2] !== 2'd1) begin
      errors++; $display("FAIL raw_cnts got x1=%0d x2=%0d exp x1=0 x2=1",
                         dut.u_sb.r_cnt[1], dut.u_sb.r_cnt[2]);
    end
    wb(5'd2, 32'd10); tick(); wb_clear();
    checks++;
    if (dut.u_sb.r_cnt[2] !== 2'd0) begin
      errors++; $display("FAIL raw_cnt2_clear got %0d exp 0", dut.u_sb.r_cnt[2]);
    end
  endtask

  task automatic test_x0();
    present(enc_addi(5'd0, 5'd0, 12'd7), 32'h200); #1;
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL x0_ready got %0b exp 1", bus.id_ready_out);
    end
    tick();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (bus.id_ex_valid !== 1'b1 || bus.id_ex_bundle.reg_wr !== 1'b0 || dut.u_sb.r_cnt[0] !== 2'd0) begin
      errors++; $display("FAIL x0_no_writer got v=%0b wr=%0b cnt0=%0d exp v=1 wr=0 cnt0=0",
                         bus.id_ex_valid, bus.id_ex_bundle.reg_wr, dut.u_sb.r_cnt[0]);
    end
    wb(5'd0, 32'hDEAD_BEEF); tick(); wb_clear();
    present(enc_add(5'd5, 5'd0, 5'd0), 32'h204); #1;
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL x0_src_ready got %0b exp 1", bus.id_ready_out);
    end
    tick();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (bus.id_ex_bundle.ra_value !== 32'd0 || bus.id_ex_bundle.rb_value !== 32'd0 ||
        dut.u_sb.r_cnt[5] !== 2'd1) begin
      errors++; $display("FAIL x0_operands got ra=%h rb=%h cnt5=%0d exp ra=0 rb=0 cnt5=1",
                         bus.id_ex_bundle.ra_value, bus.id_ex_bundle.rb_value, dut.u_sb.r_cnt[5]);
    end
    wb(5'd5, 32'd0); tick(); wb_clear();
    present(32'h0000_0000, 32'h208); tick();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (bus.id_ex_bundle.illegal !== 1'b1 || bus.id_ex_bundle.reg_wr !== 1'b0 ||
        dut.u_sb.r_cnt[0] !== 2'd0) begin
      errors++; $display("FAIL illegal_decode got ill=%0b wr=%0b exp ill=1 wr=0",
                         bus.id_ex_bundle.illegal, bus.id_ex_bundle.reg_wr);
    end
  endtask

  task automatic test_multi_writer();
    present(enc_addi(5'd3, 5'd0, 12'd1), 32'h300); tick();
    present(enc_addi(5'd3, 5'd0, 12'd2), 32'h304); tick();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (dut.u_sb.r_cnt[3] !== 2'd2) begin
      errors++; $display("FAIL multi_cnt2 got %0d exp 2", dut.u_sb.r_cnt[3]);
    end
    present(enc_add(5'd6, 5'd3, 5'd0), 32'h308);
    wb(5'd3, 32'd1); #1;
    checks++;
    if (bus.id_ready_out !== 1'b0) begin
      errors++; $display("FAIL multi_first_wb_ready got %0b exp 0", bus.id_ready_out);
    end
    tick();
    wb_clear(); #1;
    checks++;
    if (bus.id_ready_out !== 1'b0 || dut.u_sb.r_cnt[3] !== 2'd1) begin
      errors++; $display("FAIL multi_still_stalled got rdy=%0b cnt=%0d exp rdy=0 cnt=1",
                         bus.id_ready_out, dut.u_sb.r_cnt[3]);
    end
    wb(5'd3, 32'd2); #1;
`ifdef WB_BYPASS_EN
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL multi_bypass_ready got %0b exp 1", bus.id_ready_out);
    end
    tick();
    wb_clear();
`else
    checks++;
    if (bus.id_ready_out !== 1'b0) begin
      errors++; $display("FAIL multi_second_wb_ready got %0b exp 0", bus.id_ready_out);
    end
    tick();
    wb_clear();
    tick();
`endif
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (bus.id_ex_valid !== 1'b1 || bus.id_ex_bundle.ra_value !== 32'd2 ||
        bus.id_ex_bundle.dest_reg_idx !== 5'd6 || dut.u_sb.r_cnt[3] !== 2'd0) begin
      errors++; $display("FAIL multi_dep_issue got v=%0b ra=%0d rd=%0d cnt3=%0d exp v=1 ra=2 rd=6 cnt3=0",
                         bus.id_ex_valid, bus.id_ex_bundle.ra_value,
                         bus.id_ex_bundle.dest_reg_idx, dut.u_sb.r_cnt[3]);
    end
    wb(5'd6, 32'd2); tick(); wb_clear();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      present(enc_addi(5'd3, 5'd0, 12'(7 + k)), 32'h400 + 32'(4 * k));
      tick();
    end
    present(enc_addi(5'd3, 5'd0, 12'd10), 32'h40C); #1;
    checks++;
    if (dut.u_sb.r_cnt[3] !== 2'd3 || bus.id_ready_out !== 1'b0) begin
      errors++; $display("FAIL sat_full got cnt=%0d rdy=%0b exp cnt=3 rdy=0",
                         dut.u_sb.r_cnt[3], bus.id_ready_out);
    end
    wb(5'd3, 32'd7); #1;
    checks++;
    if (bus.id_ready_out !== 1'b0) begin
      errors++; $display("FAIL sat_wb_cycle_ready got %0b exp 0", bus.id_ready_out);
    end
    tick();
    wb(5'd3, 32'd8); #1;
    checks++;
    if (dut.u_sb.r_cnt[3] !== 2'd2 || bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL sat_after_wb got cnt=%0d rdy=%0b exp cnt=2 rdy=1",
                         dut.u_sb.r_cnt[3], bus.id_ready_out);
    end
    tick();
    wb_clear();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (dut.u_sb.r_cnt[3] !== 2'd2 || bus.id_ex_bundle.imm !== 32'd10) begin
      errors++; $display("FAIL sat_issue_plus_wb got cnt=%0d imm=%0d exp cnt=2 imm=10",
                         dut.u_sb.r_cnt[3], bus.id_ex_bundle.imm);
    end
    present(enc_addi(5'd3, 5'd0, 12'd11), 32'h410); tick();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (dut.u_sb.r_cnt[3] !== 2'd3) begin
      errors++; $display("FAIL sat_refill got %0d exp 3", dut.u_sb.r_cnt[3]);
    end
    for (int k = 0; k < 3; k++) begin
      wb(5'd3, 32'(9 + k)); tick();
    end
    wb_clear();
    checks++;
    if (dut.u_sb.r_cnt[3] !== 2'd0) begin
      errors++; $display("FAIL sat_drain got %0d exp 0", dut.u_sb.r_cnt[3]);
    end
  endtask

  task automatic test_flush();
    bus.ex_ready_in = 1'b0;
    present(enc_addi(5'd4, 5'd0, 12'd4), 32'h500); tick();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (bus.id_ex_valid !== 1'b1 || dut.u_sb.r_cnt[4] !== 2'd1) begin
      errors++; $display("FAIL flush_setup got v=%0b cnt=%0d exp v=1 cnt=1",
                         bus.id_ex_valid, dut.u_sb.r_cnt[4]);
    end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++;
    if (bus.id_ex_valid !== 1'b0 || dut.u_sb.r_cnt[4] !== 2'd0) begin
      errors++; $display("FAIL flush_squash got v=%0b cnt=%0d exp v=0 cnt=0",
                         bus.id_ex_valid, dut.u_sb.r_cnt[4]);
    end
    bus.ex_ready_in = 1'b1;
  endtask

  task automatic test_back_to_back();
    dec_bundle_t saved;
    bus.ex_ready_in = 1'b0;
    present(enc_addi(5'd7, 5'd0, 12'd11), 32'h600); tick();
    saved = bus.id_ex_bundle;
    checks++;
    if (saved.dest_reg_idx !== 5'd7 || saved.imm !== 32'd11) begin
      errors++; $display("FAIL bp_first got rd=%0d imm=%0d exp rd=7 imm=11",
                         saved.dest_reg_idx, saved.imm);
    end
    present(enc_addi(5'd8, 5'd0, 12'd12), 32'h604);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.id_ready_out !== 1'b0 || bus.id_ex_valid !== 1'b1 || bus.id_ex_bundle !== saved) begin
        errors++; $display("FAIL bp_hold[%0d] got rdy=%0b v=%0b bundle=%h exp rdy=0 v=1 bundle=%h",
                           c, bus.id_ready_out, bus.id_ex_valid, bus.id_ex_bundle, saved);
      end
      tick();
    end
    bus.ex_ready_in = 1'b1; #1;
    checks++;
    if (bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %0b exp 1", bus.id_ready_out);
    end
    tick();
    bus.if_id_valid_inst = 1'b0;
    checks++;
    if (bus.id_ex_valid !== 1'b1 || bus.id_ex_bundle.dest_reg_idx !== 5'd8 ||
        bus.id_ex_bundle.imm !== 32'd12) begin
      errors++; $display("FAIL bp_next_load got v=%0b rd=%0d imm=%0d exp v=1 rd=8 imm=12",
                         bus.id_ex_valid, bus.id_ex_bundle.dest_reg_idx, bus.id_ex_bundle.imm);
    end
    wb(5'd7, 32'd11); tick();
    wb(5'd8, 32'd12); tick();
    wb_clear();
    checks++;
    if (dut.u_sb.r_cnt[7] !== 2'd0 || dut.u_sb.r_cnt[8] !== 2'd0) begin
      errors++; $display("FAIL bp_drain got x7=%0d x8=%0d exp 0 0",
                         dut.u_sb.r_cnt[7], dut.u_sb.r_cnt[8]);
    end
  endtask

  task automatic test_mid_reset();
    present(enc_addi(5'd9, 5'd0, 12'd9), 32'h700); tick();
    bus.if_id_valid_inst = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++;
    if (bus.id_ex_valid !== 1'b0 || dut.u_sb.r_cnt[9] !== 2'd0 || bus.id_ready_out !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%0b cnt9=%0d rdy=%0b exp v=0 cnt9=0 rdy=1",
                         bus.id_ex_valid, dut.u_sb.r_cnt[9], bus.id_ready_out);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    test_reset();
    test_raw();
    test_x0();
    test_multi_writer();
    test_saturate();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
